alu_exec_unit: RTL and testbench

- Execute-stage arithmetic block of the single-cycle MIPS-style processor.
- Combines the ALU control decoder, a 32-bit ALU with shift support, and a general 32-bit adder (PC+4 or branch target).
- Adds a clocked status register holding the negative and zero flags, which branch/jump control consumes on later instructions.
- Everything is combinational except the status register.

---
 rtl/alu_exec_unit_if.sv | 31 +++
 rtl/alu_exec_unit.sv | 78 +++++++
 tb/tb_alu_exec_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand, control and result bundle of the execute-stage ALU block.
// The master drives operands and control; the slave (the ALU) returns results and flags.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       gout;
  logic [WIDTH-1:0] result;
  logic             alu_zero;
  logic             alu_neg;
  logic             status_we;
  logic             flag_n;
  logic             flag_z;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;

  modport slave (
    input  alu_op, funct, shamt, a, b, status_we, add_a, add_b,
    output gout, result, alu_zero, alu_neg, flag_n, flag_z, add_sum
  );

  modport master (
    output alu_op, funct, shamt, a, b, status_we, add_a, add_b,
    input  gout, result, alu_zero, alu_neg, flag_n, flag_z, add_sum
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, ALU with shifts, general adder; all combinational.
// Only the N/Z status register is clocked (one cycle behind result); no backpressure.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  logic [2:0]       w_gout;
  logic [WIDTH-1:0] w_result;
  logic             w_lt;
  logic             r_flag_n;
  logic             r_flag_z;

  always_comb begin
    w_gout = 3'b010;
    case (bus.alu_op)
      3'b000:  w_gout = 3'b010;
      3'b001:  w_gout = 3'b110;
      3'b011:  w_gout = 3'b000;
      3'b100:  w_gout = 3'b001;
      3'b101:  w_gout = 3'b111;
      3'b010: begin
        case (bus.funct)
          6'b100000: w_gout = 3'b010;
          6'b100010: w_gout = 3'b110;
          6'b100100: w_gout = 3'b000;
          6'b100101: w_gout = 3'b001;
          6'b101010: w_gout = 3'b111;
          6'b100111: w_gout = 3'b101;
          6'b000000: w_gout = 3'b011;
          6'b000010: w_gout = 3'b100;
          default:   w_gout = 3'b010;
        endcase
      end
      default: w_gout = 3'b010;
    endcase
  end

  // True signed compare, so slt is immune to a - b overflow.
  assign w_lt = ($signed(bus.a) < $signed(bus.b));

  always_comb begin
    w_result = '0;
    case (w_gout)
      3'b000:  w_result = bus.a & bus.b;
      3'b001:  w_result = bus.a | bus.b;
      3'b010:  w_result = bus.a + bus.b;
      3'b110:  w_result = bus.a - bus.b;
      3'b111:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
      3'b101:  w_result = ~(bus.a | bus.b);
      3'b011:  w_result = bus.b << bus.shamt;
      3'b100:  w_result = bus.b >> bus.shamt;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (bus.status_we) begin
      r_flag_n <= w_result[WIDTH-1];
      r_flag_z <= (w_result == '0);
    end
  end

  assign bus.gout     = w_gout;
  assign bus.result   = w_result;
  assign bus.alu_zero = (w_result == '0);
  assign bus.alu_neg  = w_result[WIDTH-1];
  assign bus.flag_n   = r_flag_n;
  assign bus.flag_z   = r_flag_z;
  assign bus.add_sum  = bus.add_a + bus.add_b;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven check of alu_exec_unit plus status-register sequences.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit_if #(.WIDTH(32)) u_if ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic        neg;
  } alu_vec_t;

  typedef struct {
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] sum;
  } add_vec_t;

  alu_vec_t vec [21];
  add_vec_t avec [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic exp_n, input logic exp_z);
    check({name, " flag_n"}, {31'd0, u_if.flag_n}, {31'd0, exp_n});
    check({name, " flag_z"}, {31'd0, u_if.flag_z}, {31'd0, exp_z});
  endtask

  task automatic drive_alu(input logic [2:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    u_if.alu_op = op;
    u_if.funct  = fn;
    u_if.a      = a;
    u_if.b      = b;
  endtask

  initial begin
    //          op      funct      shamt  a             b             gout    result        z     n
    vec[0]  = '{3'b010, 6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1};
    vec[1]  = '{3'b010, 6'b100000, 5'd0,  32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0};
    vec[2]  = '{3'b001, 6'b000000, 5'd0,  32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0};
    vec[3]  = '{3'b001, 6'b100000, 5'd0,  32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b1};
    vec[4]  = '{3'b010, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0};
    vec[5]  = '{3'b010, 6'b101010, 5'd0,  32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0};
    vec[6]  = '{3'b010, 6'b101010, 5'd0,  32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 1'b0};
    vec[7]  = '{3'b010, 6'b000000, 5'd4,  32'hDEADBEEF, 32'h80000001, 3'b011, 32'h00000010, 1'b0, 1'b0};
    vec[8]  = '{3'b010, 6'b000010, 5'd31, 32'h00000000, 32'h80000001, 3'b100, 32'h00000001, 1'b0, 1'b0};
    vec[9]  = '{3'b010, 6'b100111, 5'd0,  32'h00000000, 32'h00000000, 3'b101, 32'hFFFFFFFF, 1'b0, 1'b1};
    vec[10] = '{3'b010, 6'b111111, 5'd0,  32'h00000002, 32'h00000003, 3'b010, 32'h00000005, 1'b0, 1'b0};
    vec[11] = '{3'b011, 6'b000000, 5'd0,  32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b0, 1'b0};
    vec[12] = '{3'b100, 6'b000000, 5'd0,  32'h0000F0F0, 32'h0000FF00, 3'b001, 32'h0000FFF0, 1'b0, 1'b0};
    vec[13] = '{3'b101, 6'b000000, 5'd0,  32'h00000005, 32'h00000003, 3'b111, 32'h00000000, 1'b1, 1'b0};
    vec[14] = '{3'b110, 6'b000000, 5'd0,  32'h00000001, 32'h00000002, 3'b010, 32'h00000003, 1'b0, 1'b0};
    vec[15] = '{3'b111, 6'b000000, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFE, 1'b0, 1'b1};
    vec[16] = '{3'b010, 6'b000000, 5'd0,  32'hFFFFFFFF, 32'h00001234, 3'b011, 32'h00001234, 1'b0, 1'b0};
    vec[17] = '{3'b010, 6'b100010, 5'd0,  32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b1};
    vec[18] = '{3'b010, 6'b100100, 5'd0,  32'h000000FF, 32'h0000000F, 3'b000, 32'h0000000F, 1'b0, 1'b0};
    vec[19] = '{3'b010, 6'b100101, 5'd0,  32'h000000F0, 32'h0000000F, 3'b001, 32'h000000FF, 1'b0, 1'b0};
    vec[20] = '{3'b010, 6'b101010, 5'd0,  32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0};

    avec[0] = '{32'h0000007C, 32'h00000004, 32'h00000080};
    avec[1] = '{32'hFFFFFFFC, 32'h00000004, 32'h00000000};
    avec[2] = '{32'h12345678, 32'h11111111, 32'h23456789};

    u_if.alu_op    = 3'b000;
    u_if.funct     = 6'b000000;
    u_if.shamt     = 5'd0;
    u_if.a         = 32'd0;
    u_if.b         = 32'd0;
    u_if.status_we = 1'b0;
    u_if.add_a     = 32'd0;
    u_if.add_b     = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      u_if.alu_op = vec[i].alu_op;
      u_if.funct  = vec[i].funct;
      u_if.shamt  = vec[i].shamt;
      u_if.a      = vec[i].a;
      u_if.b      = vec[i].b;
      #1;
      check($sformatf("vec%0d gout", i),   {29'd0, u_if.gout},     {29'd0, vec[i].gout});
      check($sformatf("vec%0d result", i), u_if.result,            vec[i].result);
      check($sformatf("vec%0d zero", i),   {31'd0, u_if.alu_zero}, {31'd0, vec[i].zero});
      check($sformatf("vec%0d neg", i),    {31'd0, u_if.alu_neg},  {31'd0, vec[i].neg});
    end

    for (int i = 0; i < 3; i++) begin
      u_if.add_a = avec[i].add_a;
      u_if.add_b = avec[i].add_b;
      #1;
      check($sformatf("add%0d sum", i), u_if.add_sum, avec[i].sum);
    end

    // Reset still held: a write-enabled edge must not disturb the flags.
    @(negedge clk);
    u_if.shamt     = 5'd0;
    u_if.status_we = 1'b1;
    drive_alu(3'b001, 6'b000000, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    check_flags("held in reset", 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_flags("sub 3-5 write", 1'b1, 1'b0);

    @(negedge clk);
    u_if.status_we = 1'b0;
    drive_alu(3'b001, 6'b000000, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    check_flags("we=0 hold", 1'b1, 1'b0);

    // Mid-cycle asynchronous reset clears the flags before any edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_flags("async rst mid-cycle", 1'b0, 1'b0);
    #1;
    rst = 1'b0;

    @(negedge clk);
    u_if.status_we = 1'b1;
    drive_alu(3'b001, 6'b000000, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    check_flags("sub 5-5 write", 1'b0, 1'b1);

    // Reset coincident with a write-enabled edge wins.
    @(negedge clk);
    drive_alu(3'b001, 6'b000000, 32'd3, 32'd5);
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_flags("rst at edge", 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_flags("write after rst", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
